// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - operand capture, ALU sequencing and result accumulator for the calculator
//
// Ports:
//   clk        in   system clock, all state updates on rising edge
//   rst_n      in   synchronous reset, active-low
//   sw_val     in   [WIDTH]  operand value from switches
//   op_sel     in   [2]      operation selector (00 pass A, 01 A+B, 10 A-B, 11 NOT A)
//   btn_load   in   debounced level, rising edge loads an operand
//   btn_exec   in   debounced level, rising edge executes or chains
//   btn_clear  in   debounced level, high level clears
//   alu_result in   [WIDTH]  combinational ALU result
//   alu_a      out  [WIDTH]  registered operand A
//   alu_b      out  [WIDTH]  registered operand B
//   alu_op     out  [2]      registered op code
//   acc        out  [WIDTH]  last captured result
//   ovf        out  signed overflow of last captured result
//   busy       out  high while in EXEC
//   done       out  one-cycle pulse on result capture
//   err        out  one-cycle pulse on illegal exec
//   state      out  [3]      current FSM state
module calc_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_val,
  input  logic [1:0]       op_sel,
  input  logic             btn_load,
  input  logic             btn_exec,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    EXEC   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [WIDTH-1:0] a_n, b_n, acc_n;
  logic [1:0]       op_n;
  logic             ovf_n, done_n, err_n;
  logic             load_prev, exec_prev;
  logic             load_ev, exec_ev;
  logic             ovf_calc;

  assign load_ev = btn_load & ~load_prev;
  assign exec_ev = btn_exec & ~exec_prev;
  assign state   = cur;
  assign busy    = (cur == EXEC);

  // Sign-bit overflow test on the operands currently presented to the ALU.
  always_comb begin
    ovf_calc = 1'b0;
    case (alu_op)
      2'b01:   ovf_calc = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
      2'b10:   ovf_calc = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  end

  always_comb begin
    nxt    = cur;
    a_n    = alu_a;
    b_n    = alu_b;
    op_n   = alu_op;
    acc_n  = acc;
    ovf_n  = ovf;
    done_n = 1'b0;
    err_n  = 1'b0;
    if (btn_clear) begin
      nxt   = IDLE;
      a_n   = '0;
      b_n   = '0;
      op_n  = '0;
      acc_n = '0;
      ovf_n = 1'b0;
    end else begin
      case (cur)
        IDLE: begin
          if (load_ev) begin
            a_n = sw_val;
            nxt = HAVE_A;
          end
        end
        HAVE_A: begin
          // load wins over a simultaneous exec rise
          if (load_ev) begin
            b_n = sw_val;
            nxt = HAVE_B;
          end else if (exec_ev) begin
            if (op_sel == 2'b00 || op_sel == 2'b11) begin
              op_n = op_sel;
              nxt  = EXEC;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        HAVE_B: begin
          if (load_ev) begin
            b_n = sw_val;
          end else if (exec_ev) begin
            op_n = op_sel;
            nxt  = EXEC;
          end
        end
        EXEC: begin
          acc_n  = alu_result;
          ovf_n  = ovf_calc;
          done_n = 1'b1;
          nxt    = RESULT;
        end
        RESULT: begin
          if (load_ev) begin
            a_n = sw_val;
            b_n = '0;
            nxt = HAVE_A;
          end else if (exec_ev) begin
            a_n = acc;
            b_n = '0;
            nxt = HAVE_A;
          end
        end
        default: begin
          nxt   = IDLE;
          a_n   = '0;
          b_n   = '0;
          op_n  = '0;
          acc_n = '0;
          ovf_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      // history at 1 so a button held through reset gives no edge
      load_prev <= 1'b1;
      exec_prev <= 1'b1;
    end else begin
      cur       <= nxt;
      alu_a     <= a_n;
      alu_b     <= b_n;
      alu_op    <= op_n;
      acc       <= acc_n;
      ovf       <= ovf_n;
      done      <= done_n;
      err       <= err_n;
      load_prev <= btn_load;
      exec_prev <= btn_exec;
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - self-checking bench for calc_ctrl against a behavioural model
module tb_calc_ctrl;
  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_val;
  logic [1:0]   op_sel;
  logic         btn_load, btn_exec, btn_clear;
  logic [W-1:0] alu_result;
  logic [W-1:0] alu_a, alu_b, acc;
  logic [1:0]   alu_op;
  logic         ovf, busy, done, err;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;

  calc_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .op_sel(op_sel),
    .btn_load(btn_load), .btn_exec(btn_exec), .btn_clear(btn_clear),
    .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .acc(acc), .ovf(ovf), .busy(busy), .done(done), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a);
      2'd1:    r = int'(a) + int'(b);
      2'd2:    r = int'(a) - int'(b);
      default: r = ~int'(a);
    endcase
    return r[W-1:0];
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // overflow from true signed range, not from sign bits
  function automatic bit sgn_ovf(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    int sa, sb, res;
    int half;
    half = 1 << (W - 1);
    sa = (int'(a) >= half) ? int'(a) - 2 * half : int'(a);
    sb = (int'(b) >= half) ? int'(b) - 2 * half : int'(b);
    if (op == 2'd1) res = sa + sb;
    else if (op == 2'd2) res = sa - sb;
    else return 1'b0;
    return (res > half - 1) || (res < -half);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int           m_state;
  logic [W-1:0] m_a, m_b, m_acc;
  logic [1:0]   m_op;
  bit           m_ovf, m_done, m_err, m_pl, m_pe, m_valid;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    bit ld, ex;
    ld = btn_load && !m_pl;
    ex = btn_exec && !m_pe;
    m_pl = btn_load;
    m_pe = btn_exec;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n || btn_clear) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_acc = 0; m_ovf = 0;
      if (!rst_n) begin
        m_pl = 1'b1;
        m_pe = 1'b1;
        m_valid = 1'b1;
      end
    end else begin
      case (m_state)
        0: if (ld) begin m_a = sw_val; m_state = 1; end
        1: if (ld) begin m_b = sw_val; m_state = 2; end
           else if (ex) begin
             if (op_sel == 2'd0 || op_sel == 2'd3) begin m_op = op_sel; m_state = 3; end
             else m_err = 1'b1;
           end
        2: if (ld) m_b = sw_val;
           else if (ex) begin m_op = op_sel; m_state = 3; end
        3: begin
             m_acc = alu_fn(m_a, m_b, m_op);
             m_ovf = sgn_ovf(m_a, m_b, m_op);
             m_done = 1'b1;
             m_state = 4;
           end
        default: if (ld) begin m_a = sw_val; m_b = 0; m_state = 1; end
                 else if (ex) begin m_a = m_acc; m_b = 0; m_state = 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("state", 32'(state), 32'(m_state));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("acc", 32'(acc), 32'(m_acc));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_state == 3));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(logic [W-1:0] v);
    sw_val = v; btn_load = 1'b1; tick();
    btn_load = 1'b0; tick();
  endtask

  // returns one cycle after the exec edge is sampled (EXEC or err visible)
  task automatic do_exec(logic [1:0] op);
    op_sel = op; btn_exec = 1'b1; tick();
    btn_exec = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw_val = 5; op_sel = 0;
    btn_load = 1'b1; btn_exec = 1'b0; btn_clear = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick(); tick();
    check("held_load_state", 32'(state), 0);
    check("reset_acc", 32'(acc), 0);
    btn_load = 1'b0; tick();
    btn_load = 1'b1; tick();
    check("reload_state", 32'(state), 1);
    btn_load = 1'b0; tick();

    // 5 + 3
    do_load(3);
    do_exec(2'b01);
    check("busy_exec", 32'(busy), 1);
    tick();
    check("acc_5p3", 32'(acc), 32'b01000);
    check("ovf_5p3", 32'(ovf), 0);
    check("done_5p3", 32'(done), 1);
    check("state_result", 32'(state), 4);
    check("model_acc_5p3", 32'(m_acc), 8);

    // 12 + 7 overflows, then 3 - 5
    do_load(12); do_load(7);
    do_exec(2'b01); tick();
    check("acc_12p7", 32'(acc), 32'b10011);
    check("ovf_12p7", 32'(ovf), 1);
    check("model_ovf_12p7", 32'(m_ovf), 1);
    do_load(3); do_load(5);
    do_exec(2'b10); tick();
    check("acc_3m5", 32'(acc), 32'b11110);
    check("ovf_3m5", 32'(ovf), 0);

    // unary NOT from HAVE_A, then illegal binary exec from HAVE_A
    do_load(5'b01010);
    do_exec(2'b11); tick();
    check("acc_not", 32'(acc), 32'b10101);
    check("alu_b_not", 32'(alu_b), 0);
    do_load(5);
    do_exec(2'b01);
    check("err_pulse", 32'(err), 1);
    check("err_state", 32'(state), 1);
    tick();
    check("err_clear", 32'(err), 0);

    // 5 + 3 then chain, then - 2
    do_load(3);
    do_exec(2'b01); tick();
    check("acc_chain_src", 32'(acc), 8);
    do_exec(2'b00);
    check("chain_a", 32'(alu_a), 32'b01000);
    check("chain_state", 32'(state), 1);
    tick();
    do_load(2);
    do_exec(2'b10); tick();
    check("acc_chain", 32'(acc), 32'b00110);

    // clear during EXEC
    do_load(1); do_load(1);
    do_exec(2'b01);
    btn_clear = 1'b1; tick();
    check("clr_state", 32'(state), 0);
    check("clr_acc", 32'(acc), 0);
    check("clr_done", 32'(done), 0);
    btn_clear = 1'b0; tick();

    // simultaneous load and exec in HAVE_A
    do_load(4);
    sw_val = 9; op_sel = 0; btn_load = 1'b1; btn_exec = 1'b1; tick();
    btn_load = 1'b0; btn_exec = 1'b0;
    check("simul_state", 32'(state), 2);
    check("simul_b", 32'(alu_b), 9);
    tick();
    check("simul_busy", 32'(busy), 0);

    // randomized phase, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      sw_val    = W'($urandom);
      op_sel    = 2'($urandom);
      btn_load  = ($urandom % 4) == 0;
      btn_exec  = ($urandom % 4) == 0;
      btn_clear = ($urandom % 50) == 0;
      rst_n     = ($urandom % 300) != 0;
      tick();
    end
    rst_n = 1'b1; btn_clear = 1'b0; btn_load = 1'b0; btn_exec = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
